// File: rtl/difficulty_target_expander.sv
// Expands a compact nBits difficulty word into the 256-bit target, one byte shift per cycle.
// Optional macro DIFF_CACHE_EN re-presents the previous result when the same word is requested again.
module difficulty_target_expander #(
    parameter int MAX_SHIFT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      difficulty,
    output logic             busy,
    output logic             done,
    output logic             target_valid,
    output logic [7:0][31:0] target,
    output logic             neg_err,
    output logic             ovf_err
);

    localparam int TGT_W = 256;
    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [TGT_W-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic             shl_q;
    logic             neg_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             target_valid_q;
    logic [TGT_W-1:0] target_q;
    logic             neg_err_q;
    logic             ovf_err_q;

    // Decode of the incoming compact word, used only when a start is accepted.
    logic [8:0]       exp_ext_d;
    logic             shl_d;
    logic [8:0]       mag_d;
    logic [CNT_W-1:0] cnt_d;
    logic             neg_d;
    logic [TGT_W-1:0] work_shift_d;
    logic             ovf_d;
    logic             accept;
    logic             cache_hit;

    // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
    always_comb begin
        exp_ext_d = {1'b0, difficulty[31:24]};
        shl_d     = exp_ext_d > 9'd3;
        mag_d     = shl_d ? (exp_ext_d - 9'd3) : (9'd3 - exp_ext_d);
        cnt_d     = (mag_d > 9'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : mag_d[CNT_W-1:0];
        neg_d     = difficulty[23] && (difficulty[22:0] != 23'd0);

        work_shift_d = shl_q ? {work_q[TGT_W-9:0], 8'h00} : {8'h00, work_q[TGT_W-1:8]};
        ovf_d        = ovf_q || (shl_q && (work_q[TGT_W-1:TGT_W-8] != 8'h00));
    end

    assign accept = (state_q == S_IDLE) && start;

`ifdef DIFF_CACHE_EN
    logic [31:0] cache_diff_q;
    logic        cache_vld_q;

    assign cache_hit = cache_vld_q && target_valid_q && (difficulty == cache_diff_q);

    // The cache entry becomes valid only once the job that wrote it has completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_diff_q <= 32'd0;
            cache_vld_q  <= 1'b0;
        end else if (accept) begin
            cache_diff_q <= difficulty;
            cache_vld_q  <= 1'b0;
        end else if (state_q == S_DONE) begin
            cache_vld_q  <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            work_q         <= '0;
            cnt_q          <= '0;
            shl_q          <= 1'b0;
            neg_q          <= 1'b0;
            ovf_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            target_valid_q <= 1'b0;
            target_q       <= '0;
            neg_err_q      <= 1'b0;
            ovf_err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q         <= 1'b1;
                        target_valid_q <= 1'b0;
                        neg_err_q      <= 1'b0;
                        ovf_err_q      <= 1'b0;
                        if (cache_hit) begin
                            // Reloading the held result makes DONE reproduce it exactly.
                            work_q  <= target_q;
                            neg_q   <= neg_err_q;
                            ovf_q   <= ovf_err_q;
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            work_q  <= {{(TGT_W-23){1'b0}}, difficulty[22:0]};
                            neg_q   <= neg_d;
                            ovf_q   <= 1'b0;
                            shl_q   <= shl_d;
                            cnt_q   <= cnt_d;
                            state_q <= (cnt_d != '0) ? S_SHIFT : S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= work_shift_d;
                    ovf_q  <= ovf_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    target_q       <= (neg_q || ovf_q) ? '0 : work_q;
                    neg_err_q      <= neg_q;
                    ovf_err_q      <= ovf_q;
                    done_q         <= 1'b1;
                    target_valid_q <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign target_valid = target_valid_q;
    assign target       = target_q;
    assign neg_err      = neg_err_q;
    assign ovf_err      = ovf_err_q;

endmodule
